// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-channel data selector with manual select and masked round-robin auto-scan
// Ports: i_Clk rising-edge clock; i_Rst_n asynchronous active-low reset;
//        i_Datos packed channels (channel k at [k*WIDTH +: WIDTH]); i_Sel manual channel select;
//        i_Mode 0=manual 1=auto-scan; i_En block enable (0 = idle/hold); i_Mask auto-scan channel enables;
//        o_Salida registered data of the selected channel; o_Canal registered channel index;
//        o_Valid one-cycle pulse whenever o_Canal is (re)loaded.
module mux_scan_reg #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 50,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst_n,
   input  logic [CHANNELS*WIDTH-1:0] i_Datos,
   input  logic [SEL_W-1:0]          i_Sel,
   input  logic                      i_Mode,
   input  logic                      i_En,
   input  logic [CHANNELS-1:0]       i_Mask,
   output logic [WIDTH-1:0]          o_Salida,
   output logic [SEL_W-1:0]          o_Canal,
   output logic                      o_Valid
);
   localparam int CW = $clog2(DWELL + 1);
   typedef enum logic [1:0] {IDLE, MANUAL, AUTO} state_t;
   state_t           st_q, st_d;
   logic [WIDTH-1:0] salida_q, salida_d;
   logic [SEL_W-1:0] canal_q, canal_d, nxt;
   logic             valid_q, valid_d, entering;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] ch [CHANNELS];
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign ch[k] = i_Datos[k*WIDTH +: WIDTH];
   end
   // First enabled channel at or after 'from', wrapping past CHANNELS-1 back to 0.
   // Walking downward lets the nearest hit overwrite farther ones.
   function automatic logic [SEL_W-1:0] seek(input logic [SEL_W-1:0] from, input logic [CHANNELS-1:0] m);
      int               j;
      logic [SEL_W-1:0] idx;
      seek = from;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         j   = int'(from) + i;
         idx = SEL_W'(j >= CHANNELS ? j - CHANNELS : j);
         if (m[idx]) seek = idx;
      end
   endfunction
   always_comb begin
      st_d     = !i_En ? IDLE : i_Mode ? AUTO : MANUAL;
      entering = st_d != st_q;
      nxt      = canal_q == SEL_W'(CHANNELS - 1) ? '0 : canal_q + 1'b1;
      canal_d  = canal_q;
      salida_d = salida_q;
      valid_d  = 1'b0;
      cnt_d    = '0;
      if (st_d == MANUAL && int'(i_Sel) < CHANNELS) begin
         canal_d  = i_Sel;
         salida_d = ch[i_Sel];
         valid_d  = entering || i_Sel != canal_q;
      end else if (st_d == AUTO && |i_Mask) begin
         // Entry or a disabled current channel re-aligns at once; the search is inclusive so an
         // already-enabled channel keeps its place and starts a fresh dwell.
         if (entering || !i_Mask[canal_q]) begin
            canal_d = seek(canal_q, i_Mask);
            valid_d = 1'b1;
         end else if (cnt_q == CW'(DWELL - 1)) begin
            canal_d = seek(nxt, i_Mask);
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         salida_d = ch[canal_d];
      end
   end
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         st_q     <= IDLE;
         salida_q <= '0;
         canal_q  <= '0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         st_q     <= st_d;
         salida_q <= salida_d;
         canal_q  <= canal_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
      end
   end
   assign o_Salida = salida_q;
   assign o_Canal  = canal_q;
   assign o_Valid  = valid_q;
endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N-channel data selector; the clocked successor to the team's combinational 4:1 selector.
- Supports two modes:
  - manual: channel chosen by i_Sel.
  - auto-scan: round-robin over channels enabled in a mask, staying on each for a programmable number of cycles.
- Drives the currently selected channel index and a one-cycle o_Valid strobe on every channel change.
- Sits between sensor/data sources and display/serial output logic.

Parameters:
- WIDTH, 4, bit width of each data channel.
- CHANNELS, 4, number of input channels (2..16; need not be a power of two).
- DWELL, 50, cycles spent on each channel in auto mode (>=1).
- SEL_W, $clog2(CHANNELS), localparam, width of select/index fields.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Datos  in  CHANNELS*WIDTH  packed channels; channel k = i_Datos[k*WIDTH +: WIDTH].
- i_Sel  in  SEL_W  manual channel select.
- i_Mode  in  1  0 = manual, 1 = auto-scan.
- i_En  in  1  block enable; 0 = idle/hold.
- i_Mask  in  CHANNELS  auto-scan channel enable, bit k = channel k.
- o_Salida  out  WIDTH  registered data of the selected channel.
- o_Canal  out  SEL_W  registered index of the selected channel.
- o_Valid  out  1  one-cycle pulse when o_Canal is (re)loaded.

Behaviour:
- Reset: one clock, reset is asynchronous and active-low (i_Clk, i_Rst_n). Assertion at any time, including mid-dwell or mid-transition, immediately forces:
  - o_Salida=0, o_Canal=0, o_Valid=0.
  - dwell counter=0, state=IDLE.
- FSM states: IDLE, MANUAL, AUTO. Evaluated every rising edge:
  - i_En=0 -> IDLE.
  - i_En=1, i_Mode=0 -> MANUAL.
  - i_En=1, i_Mode=1 -> AUTO.
- Every state change clears the dwell counter.
- IDLE:
  - o_Salida and o_Canal hold; o_Valid=0; counter held at 0.
- MANUAL:
  - Latency 1 cycle: o_Canal<=i_Sel and o_Salida<=channel i_Sel.
  - o_Salida is reloaded every cycle, so it tracks live data changes.
  - o_Valid=1 in the cycle after i_Sel differs from o_Canal, and on the first cycle after entering MANUAL.
  - i_Sel>=CHANNELS (illegal): o_Canal and o_Salida hold, o_Valid=0.
  - i_Mask is ignored.
- AUTO:
  - o_Salida<=channel o_Canal every cycle (live tracking).
  - Counter runs 0..DWELL-1. At DWELL-1 it wraps to 0 and o_Canal advances to the next set bit of i_Mask, searching o_Canal+1 upward with wrap to 0.
  - The new channel's data appears on o_Salida in the same edge as o_Canal; o_Valid=1 on that edge.
  - Single enabled channel equal to o_Canal: o_Canal stays, o_Valid still pulses each DWELL period.
  - i_Mask=0: o_Canal/o_Salida hold, counter held at 0, o_Valid=0.
  - On entry, or whenever o_Canal's mask bit is 0: advance to the next enabled channel on the next edge without waiting out the dwell; o_Valid=1.
  - DWELL=1: advances every cycle; o_Valid stays high continuously while channels rotate.
  - Mask changes take effect at the next search; they do not reset the counter.
- Simultaneous events: a mode/enable change in the same cycle as dwell expiry takes the new state's action; no AUTO advance.
- Widths: counter is $clog2(DWELL+1) bits. Channel index wrap uses a compare against CHANNELS-1, never a power-of-two overflow.

Test Plan:
- Reset: drive i_Rst_n=0 mid-run with o_Canal=2 -> o_Salida=0, o_Canal=0, o_Valid=0 asynchronously, before the next clock edge.
- Manual: Datos={4,3,2,5} (ch3..ch0), i_Mode=0, i_En=1, i_Sel 0->1->2->3 every 50 cycles:
  - o_Salida 5,2,3,4, each appearing 1 cycle after the i_Sel change.
  - One o_Valid pulse per change.
  - Changing ch1 to 9 while selected -> o_Salida=9 next cycle, no o_Valid.
- Auto full mask: i_Mode=1, i_Mask=4'b1111, DWELL=50:
  - o_Canal sequence 0,1,2,3,0; each held 50 cycles.
  - o_Valid pulses exactly every 50 cycles; wrap 3->0 verified.
- Auto sparse mask: i_Mask=4'b1010, starting at ch0:
  - Immediate jump to ch1 (o_Valid=1), then 1,3,1,3 at 50-cycle spacing.
  - i_Mask=0 -> hold, o_Valid stays 0.
- Non-power-of-two: CHANNELS=3, WIDTH=8:
  - i_Sel=3 -> outputs hold, no o_Valid.
  - Auto wraps 2->0.
  - DWELL=1 -> o_Canal changes every cycle with o_Valid held high.
- Mode/enable switching:
  - i_En=0 mid-dwell -> outputs hold, o_Valid=0.
  - Re-enable in AUTO -> counter restarts at 0; the next advance comes a full 50 cycles after re-entry.
